// File: rtl/score_calc_pkg.sv
// Shared definitions for the attention score engine: controller states,
// geometry constants and the FP32 arithmetic primitives.
package score_calc_pkg;

    localparam int N_ROWS  = 4;
    localparam int VEC_LEN = 128;
    localparam int LANES   = 4;
    localparam int TILES   = 32;
    localparam int ADDR_W  = 7;

    typedef enum logic [4:0] {
        IDLE      = 5'd0,
        SET_ADDR  = 5'd1,
        WAIT_MEM  = 5'd2,
        LATCH_MEM = 5'd3,
        START_MUL = 5'd4,
        WAIT_MUL  = 5'd5,
        START_L1  = 5'd6,
        WAIT_L1   = 5'd7,
        START_L2  = 5'd8,
        WAIT_L2   = 5'd9,
        START_ACC = 5'd10,
        WAIT_ACC  = 5'd11,
        NEXT_TILE = 5'd12,
        WRITE     = 5'd13,
        NEXT_IJ   = 5'd14
    } state_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    // Single-precision multiply, round-to-nearest-even; subnormals flush to zero.
    function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
        logic              sgn;
        logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0]       prod;
        logic [22:0]       man;
        logic              grd, stk;
        logic [24:0]       rnd;
        logic signed [9:0] exp;
        logic [31:0]       res;
        sgn    = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        exp    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            man = prod[46:24];
            grd = prod[23];
            stk = |prod[22:0];
            exp = exp + 10'sd1;
        end else begin
            man = prod[45:23];
            grd = prod[22];
            stk = |prod[21:0];
        end
        rnd = {2'b01, man};
        if (grd && (stk || man[0])) rnd = rnd + 25'd1;
        if (rnd[24]) begin
            rnd = rnd >> 1;
            exp = exp + 10'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = FP32_QNAN;
        else if (a_inf || b_inf)                                       res = {sgn, 8'hFF, 23'd0};
        else if (a_zero || b_zero)                                     res = {sgn, 31'd0};
        else if (exp >= 10'sd255)                                      res = {sgn, 8'hFF, 23'd0};
        else if (exp <= 10'sd0)                                        res = {sgn, 31'd0};
        else                                                           res = {sgn, exp[7:0], rnd[22:0]};
        return res;
    endfunction

    // Single-precision add, round-to-nearest-even; exact cancellation gives +0.
    function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       big, sml, res;
        logic [7:0]        diff;
        logic [27:0]       mb, ms, sum;
        logic [4:0]        msb, lsh;
        logic              stk;
        logic [24:0]       rnd;
        logic signed [9:0] exp;
        logic              a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a[30:0] < b[30:0]) begin
            big = b;
            sml = a;
        end else begin
            big = a;
            sml = b;
        end
        diff = big[30:23] - sml[30:23];
        mb   = {2'b01, big[22:0], 3'b000};
        ms   = {2'b01, sml[22:0], 3'b000};
        stk  = 1'b0;
        if (diff >= 8'd27) begin
            ms = 28'd1;
        end else begin
            for (int n = 0; n < 27; n++)
                if (n < int'(diff)) stk = stk | ms[n];
            ms    = ms >> diff;
            ms[0] = ms[0] | stk;
        end
        if (big[31] == sml[31]) sum = mb + ms;
        else                    sum = mb - ms;
        exp = $signed({2'b00, big[30:23]});
        msb = 5'd0;
        lsh = 5'd0;
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            exp = exp + 10'sd1;
        end else begin
            for (int n = 0; n < 27; n++)
                if (sum[n]) msb = 5'(n);
            lsh = 5'd26 - msb;
            sum = sum << lsh;
            exp = exp - $signed({5'b00000, lsh});
        end
        rnd = {1'b0, sum[26:3]};
        if (sum[2] && (sum[1] || sum[0] || sum[3])) rnd = rnd + 25'd1;
        if (rnd[24]) begin
            rnd = rnd >> 1;
            exp = exp + 10'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) res = FP32_QNAN;
        else if (a_inf)                                              res = a;
        else if (b_inf)                                              res = b;
        else if (a[30:23] == 8'h00 && b[30:23] == 8'h00)             res = {a[31] & b[31], 31'd0};
        else if (a[30:23] == 8'h00)                                  res = b;
        else if (b[30:23] == 8'h00)                                  res = a;
        else if (sum == 28'd0)                                       res = 32'd0;
        else if (exp >= 10'sd255)                                    res = {big[31], 8'hFF, 23'd0};
        else if (exp <= 10'sd0)                                      res = {big[31], 31'd0};
        else                                                         res = {big[31], exp[7:0], rnd[22:0]};
        return res;
    endfunction

endpackage

// File: rtl/score_calc_4x128_regfile_fp32_dot4.sv
// Four-lane FP32 dot-product slice: lane products, then a fixed two-level
// adder tree ((p0+p1)+(p2+p3)). Each level reads the previous level's
// registered result so the controller can pipeline the stages.
module fp32_dot4
    import score_calc_pkg::*;
(
    input  logic [127:0] q_word,
    input  logic [127:0] k_word,
    output logic [127:0] prod,
    input  logic [127:0] prod_q,
    output logic [63:0]  l1_sum,
    input  logic [63:0]  l1_q,
    output logic [31:0]  tile
);

    // Combinational multiply and add tree; summation order fixed for bit-exactness
    always_comb begin
        prod = '0;
        for (int k = 0; k < LANES; k++)
            prod[32*k +: 32] = fp32_mul(q_word[32*k +: 32], k_word[32*k +: 32]);
        l1_sum[31:0]  = fp32_add(prod_q[31:0],  prod_q[63:32]);
        l1_sum[63:32] = fp32_add(prod_q[95:64], prod_q[127:96]);
        tile          = fp32_add(l1_q[31:0], l1_q[63:32]);
    end

endmodule

// File: rtl/score_calc_4x128_regfile.sv
// Attention score engine: streams 4 Q rows and 4 K rows (128 FP32 each)
// from external SRAMs, four lanes per word, and accumulates the 4x4
// dot-product matrix into a 16-entry register file with a registered read port.
module score_calc_4x128_regfile
    import score_calc_pkg::*;
#(
    parameter int MEM_LAT = 3,
    parameter int FP_LAT  = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [127:0]      Q_mem_out,
    input  logic [127:0]      K_mem_out,
    input  logic              Reg_WrEn,
    output logic [ADDR_W-1:0] Q_mem_addr,
    output logic [ADDR_W-1:0] K_mem_addr,
    output logic [511:0]      score_flat,
    input  logic [3:0]        score_rd_addr,
    input  logic              score_rd_en,
    output logic [31:0]       score_rd_data,
    output logic              busy,
    output logic              done
);

    state_t        state, next_state;
    logic [1:0]    i, j;
    logic [4:0]    t;
    logic [7:0]    wait_cnt;
    logic          is_wait, wait_last, last_pair;
    logic [127:0]  qreg, kreg, prod, prod_reg;
    logic [63:0]   l1_sum, l1_reg;
    logic [31:0]   tile, tile_reg, acc, acc_sum;
    logic [31:0]   score [16];

    fp32_dot4 u_dot4 (
        .q_word (qreg),
        .k_word (kreg),
        .prod   (prod),
        .prod_q (prod_reg),
        .l1_sum (l1_sum),
        .l1_q   (l1_reg),
        .tile   (tile)
    );

    // Running accumulator adder lives here so the dot4 slice stays stateless
    assign acc_sum   = fp32_add(acc, tile_reg);
    assign last_pair = (i == 2'(N_ROWS - 1)) && (j == 2'(N_ROWS - 1));

    // Wait-state bookkeeping: memory waits last MEM_LAT cycles, FP waits FP_LAT
    always_comb begin
        is_wait   = (state == WAIT_MEM) || (state == WAIT_MUL) || (state == WAIT_L1) ||
                    (state == WAIT_L2)  || (state == WAIT_ACC);
        wait_last = 1'b0;
        if (state == WAIT_MEM) wait_last = (wait_cnt == 8'(MEM_LAT - 1));
        else if (is_wait)      wait_last = (wait_cnt == 8'(FP_LAT - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic: one tile per SET_ADDR..NEXT_TILE loop, one score per WRITE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (Reg_WrEn) next_state = SET_ADDR;
            SET_ADDR:  next_state = WAIT_MEM;
            WAIT_MEM:  if (wait_last) next_state = LATCH_MEM;
            LATCH_MEM: next_state = START_MUL;
            START_MUL: next_state = WAIT_MUL;
            WAIT_MUL:  if (wait_last) next_state = START_L1;
            START_L1:  next_state = WAIT_L1;
            WAIT_L1:   if (wait_last) next_state = START_L2;
            START_L2:  next_state = WAIT_L2;
            WAIT_L2:   if (wait_last) next_state = START_ACC;
            START_ACC: next_state = WAIT_ACC;
            WAIT_ACC:  if (wait_last) next_state = NEXT_TILE;
            NEXT_TILE: next_state = (t == 5'(TILES - 1)) ? WRITE : SET_ADDR;
            WRITE:     next_state = NEXT_IJ;
            NEXT_IJ:   next_state = last_pair ? IDLE : SET_ADDR;
            default:   next_state = IDLE;
        endcase
    end

    // Datapath: addresses, operand capture, staged FP results, indices and the score file
    always_ff @(posedge clk) begin
        if (rst) begin
            i          <= '0;
            j          <= '0;
            t          <= '0;
            wait_cnt   <= '0;
            acc        <= '0;
            Q_mem_addr <= '0;
            K_mem_addr <= '0;
            qreg       <= '0;
            kreg       <= '0;
            prod_reg   <= '0;
            l1_reg     <= '0;
            tile_reg   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int n = 0; n < 16; n++) score[n] <= '0;
        end else begin
            if (is_wait && !wait_last) wait_cnt <= wait_cnt + 8'd1;
            else                       wait_cnt <= '0;
            case (state)
                IDLE: begin
                    if (Reg_WrEn) begin
                        i    <= '0;
                        j    <= '0;
                        t    <= '0;
                        acc  <= '0;
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                SET_ADDR: begin
                    Q_mem_addr <= {i, t};
                    K_mem_addr <= {j, t};
                end
                LATCH_MEM: begin
                    qreg <= Q_mem_out;
                    kreg <= K_mem_out;
                end
                WAIT_MUL: if (wait_last) prod_reg <= prod;
                WAIT_L1:  if (wait_last) l1_reg   <= l1_sum;
                WAIT_L2:  if (wait_last) tile_reg <= tile;
                WAIT_ACC: if (wait_last) acc      <= acc_sum;
                NEXT_TILE: begin
                    if (t != 5'(TILES - 1)) t <= t + 5'd1;
                end
                WRITE: score[{i, j}] <= acc;
                NEXT_IJ: begin
                    t   <= '0;
                    acc <= '0;
                    if (j != 2'(N_ROWS - 1)) begin
                        j <= j + 2'd1;
                    end else if (i != 2'(N_ROWS - 1)) begin
                        j <= '0;
                        i <= i + 2'd1;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered read port; holds its value when not strobed
    always_ff @(posedge clk) begin
        if (rst)              score_rd_data <= '0;
        else if (score_rd_en) score_rd_data <= score[score_rd_addr];
    end

    // Flat view of the whole score file
    always_comb begin
        score_flat = '0;
        for (int n = 0; n < 16; n++) score_flat[32*n +: 32] = score[n];
    end

endmodule

// File: tb/tb_score_calc_4x128_regfile.sv
// Self-checking bench for score_calc_4x128_regfile: SRAM models with read
// latency, table-driven score checks and hand-written multi-cycle sequences.
module tb_score_calc_4x128_regfile;
    import score_calc_pkg::*;

    localparam int MEM_LAT = 3;
    localparam int BUDGET  = 10000;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] Q_mem_out, K_mem_out;
    logic         Reg_WrEn;
    logic [6:0]   Q_mem_addr, K_mem_addr;
    logic [511:0] score_flat;
    logic [3:0]   score_rd_addr;
    logic         score_rd_en;
    logic [31:0]  score_rd_data;
    logic         busy, done;

    logic [127:0] qmem [128];
    logic [127:0] kmem [128];
    logic [6:0]   qa1 = '0, qa2 = '0, qa3 = '0;
    logic [6:0]   ka1 = '0, ka2 = '0, ka3 = '0;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] expected;
    } vec_t;
    vec_t vecs [16];

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [3:0]  write_log [$];
    logic        busy_dropped;
    int          cycles;

    score_calc_4x128_regfile #(.MEM_LAT(MEM_LAT), .FP_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .Q_mem_out     (Q_mem_out),
        .K_mem_out     (K_mem_out),
        .Reg_WrEn      (Reg_WrEn),
        .Q_mem_addr    (Q_mem_addr),
        .K_mem_addr    (K_mem_addr),
        .score_flat    (score_flat),
        .score_rd_addr (score_rd_addr),
        .score_rd_en   (score_rd_en),
        .score_rd_data (score_rd_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // SRAM models: data for an address registered at edge E appears from edge E+3
    always @(posedge clk) begin
        qa1 <= Q_mem_addr; qa2 <= qa1; qa3 <= qa2;
        ka1 <= K_mem_addr; ka2 <= ka1; ka3 <= ka2;
    end
    assign Q_mem_out = qmem[qa3];
    assign K_mem_out = kmem[ka3];

    // Record the (i,j) index of every WRITE cycle
    always @(negedge clk) begin
        if (!rst && dut.state == WRITE) write_log.push_back({dut.i, dut.j});
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One-cycle start pulse driven between edges
    task automatic applyStimulus();
        @(negedge clk) Reg_WrEn = 1'b1;
        @(negedge clk) Reg_WrEn = 1'b0;
    endtask

    // Wait for done under a cycle budget, optionally pulsing Reg_WrEn mid-run
    task automatic runToDone(input int pulse_at);
        busy_dropped = 1'b0;
        cycles       = 0;
        while (!done && cycles < BUDGET) begin
            @(negedge clk);
            Reg_WrEn = (cycles == pulse_at);
            if (!done && !busy) busy_dropped = 1'b1;
            cycles++;
        end
        Reg_WrEn = 1'b0;
        checkOutput("done_within_budget", 32'(done), 32'd1);
        checkOutput("busy_held_during_run", 32'(busy_dropped), 32'd0);
        checkOutput("busy_low_after_done", 32'(busy), 32'd0);
    endtask

    // Read every table entry through the read port and the flat bus
    task automatic checkVectors(input string tag);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            score_rd_addr = vecs[n].idx;
            score_rd_en   = 1'b1;
            @(negedge clk);
            score_rd_en = 1'b0;
            checkOutput($sformatf("%s_rd[%0d]", tag, vecs[n].idx), score_rd_data, vecs[n].expected);
            checkOutput($sformatf("%s_flat[%0d]", tag, vecs[n].idx),
                        score_flat[32*int'(vecs[n].idx) +: 32], vecs[n].expected);
        end
    endtask

    task automatic checkWriteOrder(input string tag);
        checkOutput({tag, "_write_count"}, 32'(write_log.size()), 32'd16);
        for (int n = 0; n < 16 && n < write_log.size(); n++)
            checkOutput($sformatf("%s_write_order[%0d]", tag, n), 32'(write_log[n]), 32'(n));
    endtask

    function automatic logic [31:0] toFp32(input real v);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(v);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    initial begin
        logic [31:0] qv [4];
        logic [31:0] kv [4];
        real         qr [4][128];
        real         kr [4][128];
        real         p0, p1, p2, p3, acc;

        rst           = 1'b1;
        Reg_WrEn      = 1'b0;
        score_rd_en   = 1'b0;
        score_rd_addr = '0;
        for (int a = 0; a < 128; a++) begin
            qmem[a] = '0;
            kmem[a] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 32'(dut.state), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_rd_data", score_rd_data, 32'd0);
        checkOutput("reset_scores_zero", 32'(|score_flat), 32'd0);
        checkOutput("reset_addr", {18'd0, Q_mem_addr, K_mem_addr}, 32'd0);
        rst = 1'b0;

        // Uniform rows: Q row i = (i+1).0, K row j = 0.5*(j+1)
        qv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        kv = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000};
        for (int r = 0; r < 4; r++)
            for (int w = 0; w < 32; w++) begin
                qmem[r*32+w] = {4{qv[r]}};
                kmem[r*32+w] = {4{kv[r]}};
            end
        vecs = '{
            '{4'd0,  32'h42800000}, '{4'd1,  32'h43000000}, '{4'd2,  32'h43400000}, '{4'd3,  32'h43800000},
            '{4'd4,  32'h43000000}, '{4'd5,  32'h43800000}, '{4'd6,  32'h43C00000}, '{4'd7,  32'h44000000},
            '{4'd8,  32'h43400000}, '{4'd9,  32'h43C00000}, '{4'd10, 32'h44100000}, '{4'd11, 32'h44400000},
            '{4'd12, 32'h43800000}, '{4'd13, 32'h44000000}, '{4'd14, 32'h44400000}, '{4'd15, 32'h44800000}
        };

        // First run, with an extra start pulse mid-run that must be ignored
        write_log.delete();
        applyStimulus();
        checkOutput("start_busy", 32'(busy), 32'd1);
        runToDone(1000);
        checkWriteOrder("run1");
        checkVectors("run1");

        // Read port: strobe address 5, then verify the value holds with rd_en low
        @(negedge clk);
        score_rd_addr = 4'd5;
        score_rd_en   = 1'b1;
        @(negedge clk);
        score_rd_en   = 1'b0;
        score_rd_addr = 4'd15;
        checkOutput("rd_addr5", score_rd_data, 32'h43800000);
        repeat (3) @(negedge clk);
        checkOutput("rd_hold", score_rd_data, 32'h43800000);

        // Second start after done: done drops, same results again
        write_log.delete();
        applyStimulus();
        checkOutput("restart_done_cleared", 32'(done), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        runToDone(-1);
        checkWriteOrder("run2");
        checkVectors("run2");

        // Leave a known value in the read register, then reset mid-run
        @(negedge clk);
        score_rd_addr = 4'd15;
        score_rd_en   = 1'b1;
        @(negedge clk);
        score_rd_en = 1'b0;
        applyStimulus();
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_state", 32'(dut.state), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_scores_zero", 32'(|score_flat), 32'd0);
        checkOutput("midreset_rd_data", score_rd_data, 32'd0);
        rst = 1'b0;

        // Mixed-sign data with cancellation; expected values from an ordered reference sum
        for (int r = 0; r < 4; r++)
            for (int e = 0; e < 128; e++) begin
                qr[r][e] = (((e + r) % 2) == 0) ? 1.5 : -1.5;
                kr[r][e] = ((e % 4) == r) ? -2.0 : 2.0;
            end
        for (int r = 0; r < 4; r++)
            for (int w = 0; w < 32; w++)
                for (int k = 0; k < 4; k++) begin
                    qmem[r*32+w][32*k +: 32] = toFp32(qr[r][4*w+k]);
                    kmem[r*32+w][32*k +: 32] = toFp32(kr[r][4*w+k]);
                end
        for (int qi = 0; qi < 4; qi++)
            for (int kj = 0; kj < 4; kj++) begin
                acc = 0.0;
                for (int w = 0; w < 32; w++) begin
                    p0  = qr[qi][4*w]   * kr[kj][4*w];
                    p1  = qr[qi][4*w+1] * kr[kj][4*w+1];
                    p2  = qr[qi][4*w+2] * kr[kj][4*w+2];
                    p3  = qr[qi][4*w+3] * kr[kj][4*w+3];
                    acc = acc + ((p0 + p1) + (p2 + p3));
                end
                vecs[qi*4+kj].idx      = 4'(qi*4 + kj);
                vecs[qi*4+kj].expected = toFp32(acc);
            end
        write_log.delete();
        applyStimulus();
        runToDone(-1);
        checkWriteOrder("mixed");
        checkVectors("mixed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/score_calc_4x128_regfile.md
Name: score_calc_4x128_regfile

Overview:
- Attention score engine. Computes the 4x4 FP32 dot-product matrix score[i][j] = sum over e of Q[i][e]*K[j][e], with 4 rows of Q and 4 rows of K, each 128 FP32 elements long.
- Operands are streamed from two external 128x128-bit SRAMs (Q and K), four lanes per word.
- Results are held in an internal 16-entry register file, exposed both flat and through a registered read port.

Parameters:
- MEM_LAT, 3: SRAM read latency. Data for an address registered at edge E is valid on *_mem_out from edge E+MEM_LAT.
- FP_LAT, 1: cycles a WAIT_* state holds for each FP stage. The fp32_mul/fp32_add primitives are combinational, and their results are registered on the last wait cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Q_mem_out  in  128  Q SRAM read data. Lane k = bits [32k+:32].
- K_mem_out  in  128  K SRAM read data, same lane layout.
- Reg_WrEn  in  1  start pulse. Honoured only in IDLE.
- Q_mem_addr  out  7  registered Q SRAM address.
- K_mem_addr  out  7  registered K SRAM address.
- score_flat  out  512  all scores. Index idx=i*4+j sits at bits [32*idx+:32].
- score_rd_addr  in  4  read index.
- score_rd_en  in  1  read strobe.
- score_rd_data  out  32  registered read data.
- busy  out  1  high from start acceptance until the final write completes.
- done  out  1  sticky completion flag.

Behaviour:
- Memory layout: row r of Q occupies addresses r*32+t, t=0..31. Word t holds elements 4t..4t+3 in lanes 0..3. K uses the same layout.
- Reset values: state=IDLE; i,j,t=0; acc=0; addresses=0; all 16 scores=0; score_rd_data=0; busy=0; done=0. Reset mid-run aborts the run immediately.
- State encoding (5-bit):
  - IDLE=0, SET_ADDR=1, WAIT_MEM=2, LATCH_MEM=3
  - START_MUL=4, WAIT_MUL=5
  - START_L1=6, WAIT_L1=7
  - START_L2=8, WAIT_L2=9
  - START_ACC=10, WAIT_ACC=11
  - NEXT_TILE=12, WRITE=13, NEXT_IJ=14
- IDLE: when Reg_WrEn=1, set i=j=t=0, acc=+0.0, busy=1, done=0, and go to SET_ADDR. Reg_WrEn is ignored in every other state.
- SET_ADDR: Q_mem_addr<=i*32+t, K_mem_addr<=j*32+t. Addresses are held constant until the next SET_ADDR.
- WAIT_MEM: wait_cnt counts MEM_LAT cycles, then LATCH_MEM.
- LATCH_MEM: capture Q_mem_out/K_mem_out into qreg/kreg.
- Arithmetic: IEEE-754 single, round-to-nearest-even. Each START_x/WAIT_x pair lasts 1+FP_LAT cycles.
  - MUL: p[k]=q[k]*k[k] for k=0..3.
  - L1: s0=p0+p1, s1=p2+p3.
  - L2: tile=s0+s1.
  - ACC: acc=acc+tile.
  - Summation order is fixed as above (bit-exactness).
- NEXT_TILE: if t<31, t++ and go to SET_ADDR; else go to WRITE.
- WRITE: score[i*4+j]<=acc. Exactly one cycle.
- NEXT_IJ: clear t and acc. Iteration order is j inner, i outer.
  - If j<3: j++.
  - Else if i<3: j=0, i++.
  - Else: go to IDLE with busy=0, done=1.
- done stays high until the next accepted start. Scores persist until overwritten by the next run.
- Read port: if score_rd_en=1, score_rd_data<=score[score_rd_addr] next cycle; otherwise score_rd_data holds. Reading during a run returns the current register content.
- Full run: 16 WRITE events and at most 10000 cycles at default parameters.

Decomposition:
- Shared package score_calc_pkg holds:
  - the state enum (values above);
  - constants N_ROWS=4, VEC_LEN=128, LANES=4, TILES=32, ADDR_W=7.
- One natural sub-module, fp32_dot4: 4 fp32_mul plus a two-level fp32_add tree, producing the tile sum. The accumulate adder stays in the top level.

Test Plan:
- Reset, then pulse Reg_WrEn, with Q row i all (i+1).0 and K row j all 0.5*(j+1) -> done=1 within 10000 cycles; score(i,j)=64*(i+1)*(j+1) bit-exact (e.g. idx 0=0x42800000, idx 15=0x44800000).
- During the run -> exactly 16 WRITE events in order idx 0..15; Q/K addresses never X while busy; busy=1 throughout and 0 after done.
- After done, score_rd_en=1 with addr=5 -> score_rd_data=256.0 (0x43800000) one cycle later; with rd_en=0 the value holds.
- Reg_WrEn pulsed mid-run -> ignored, results unchanged. A second start after done -> done drops, recomputes, and finishes identically.
- Assert rst mid-run -> next cycle state=IDLE, busy=0, done=0, scores=0, score_rd_data=0.
- Mixed-sign data (Q lane values ±1.5, K values 2.0 with cancellation) -> each score matches a reference model using the specified summation order bit-exactly.
